// File: rtl/mpt_multi_fetch_stage_if.sv
// Requester-side and downstream-side handshake bundle of the multi-channel MPT fetch stage.
interface mpt_multi_fetch_stage_if #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned CH_W         = 2
);
    logic [NUM_CHANNELS-1:0]            slave_valid;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] slave_data;
    logic [NUM_CHANNELS-1:0]            slave_ready;
    logic                               master_valid;
    logic [DATA_WIDTH-1:0]              master_data;
    logic                               master_ready;
    logic [CH_W-1:0]                    master_channel;

    // slave: the fetch stage itself; master: requesters plus downstream consumer
    modport slave (
        input  slave_valid, slave_data, master_ready,
        output slave_ready, master_valid, master_data, master_channel
    );

    modport master (
        output slave_valid, slave_data, master_ready,
        input  slave_ready, master_valid, master_data, master_channel
    );
endinterface

// File: rtl/mpt_multi_fetch_stage.sv
// Multi-channel MPT walker fetch stage: round-robin arbitration, SPA format check, output FIFO.
// Optional MPT_FETCH_PERF_CNT_EN adds saturating accept/fault counters.
package mpt_fetch_pkg;

    typedef enum logic [1:0] {
        NO_ERROR       = 2'd0,
        NOT_VALID_ADDR = 2'd1
    } page_format_fault_e;

    typedef enum logic {
        MPT_WALKING_SKIP = 1'b0,
        MPT_WALKING_DO   = 1'b1
    } mpt_walking_e;

    // MODE values 4..15 are reserved
    localparam logic [3:0] MODE_BARE    = 4'd0;
    localparam logic [3:0] MODE_SMMPT43 = 4'd1;
    localparam logic [3:0] MODE_SMMPT52 = 4'd2;
    localparam logic [3:0] MODE_SMMPT64 = 4'd3;

    typedef struct packed {
        logic [4:0]  zero;
        logic [17:0] ppn;
    } spa43_t;

    typedef struct packed {
        logic [1:0]  zero;
        logic [20:0] ppn;
    } spa52_t;

    typedef union packed {
        spa43_t spa43;
        spa52_t spa52;
    } spa_t;

    // 32-bit packed transaction; DATA_WIDTH must equal $bits(mptw_transaction_t)
    typedef struct packed {
        logic               valid;
        logic               access_error;
        mpt_walking_e       walking;
        page_format_fault_e format_error;
        logic [3:0]         mode;
        spa_t               spa;
    } mptw_transaction_t;

endpackage

module mpt_multi_fetch_stage
    import mpt_fetch_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS    = 4,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter logic [3:0]  SUPPORTED_MODES = 4'b1110,
    localparam int unsigned CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    mpt_multi_fetch_stage_if.slave stage,
    input  logic                   stage_ctrl_flush_i,
    input  logic                   stage_ctrl_stall_i,
    output logic                   exception_valid_o,
    output page_format_fault_e     exception_cause_o,
    output logic [CH_W-1:0]        exception_channel_o,
    output logic [CNT_W-1:0]       fifo_count_o
`ifdef MPT_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            perf_accept_cnt_o,
    output logic [31:0]            perf_fault_cnt_o
`endif
);

    localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CHANNELS - 1);

    mptw_transaction_t  mem_data [FIFO_DEPTH];
    logic [CH_W-1:0]    mem_chan [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CH_W-1:0]    rr_ptr;

    logic                    pop, can_accept, grant_any;
    logic [CH_W-1:0]         grant_idx;
    logic [NUM_CHANNELS-1:0] grant_vec;
    mptw_transaction_t       txn, stored;
    page_format_fault_e      fault;

    assign pop        = stage.master_valid && stage.master_ready && !stage_ctrl_flush_i;
    assign can_accept = rst_ni && !stage_ctrl_stall_i && !stage_ctrl_flush_i
                        && ((count < DEPTH_C) || pop);

    always_comb begin
        int unsigned     idx;
        logic [CH_W-1:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        idx       = 0;
        cand      = '0;
        if (can_accept) begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                idx = 32'(rr_ptr) + i;
                if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
                cand = CH_W'(idx);
                if (!grant_any && stage.slave_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (grant_any) grant_vec[grant_idx] = 1'b1;
    end

    assign stage.slave_ready = grant_vec;
    assign txn = mptw_transaction_t'(stage.slave_data[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH]);

    always_comb begin
        fault = NO_ERROR;
        if (txn.valid) begin
            case (txn.mode)
                MODE_SMMPT43: if (txn.spa.spa43.zero != '0) fault = NOT_VALID_ADDR;
                MODE_SMMPT52: if (txn.spa.spa52.zero != '0) fault = NOT_VALID_ADDR;
                MODE_SMMPT64: fault = NO_ERROR;
                default:      fault = NOT_VALID_ADDR;
            endcase
            if (txn.mode[3:2] == 2'b00 && !SUPPORTED_MODES[txn.mode[1:0]]) fault = NOT_VALID_ADDR;
        end
        // invalid transactions are never walked, even without a format fault
        stored              = txn;
        stored.walking      = (txn.valid && fault == NO_ERROR) ? MPT_WALKING_DO : MPT_WALKING_SKIP;
        stored.format_error = fault;
        if (!txn.valid) stored.access_error = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_chan[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else begin
            if (grant_any) begin
                mem_data[wr_ptr] <= stored;
                mem_chan[wr_ptr] <= grant_idx;
                rr_ptr           <= (grant_idx == LAST_CH) ? '0 : grant_idx + CH_W'(1);
            end
            if (stage_ctrl_flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (grant_any) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)       rd_ptr <= rd_ptr + PTR_W'(1);
                case ({grant_any, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exception_valid_o   <= 1'b0;
            exception_cause_o   <= NO_ERROR;
            exception_channel_o <= '0;
        end else begin
            exception_valid_o <= grant_any && (fault != NO_ERROR);
            if (grant_any && fault != NO_ERROR) begin
                exception_cause_o   <= fault;
                exception_channel_o <= grant_idx;
            end
        end
    end

    assign stage.master_valid   = (count != '0);
    assign stage.master_data    = mem_data[rd_ptr];
    assign stage.master_channel = mem_chan[rd_ptr];
    assign fifo_count_o         = count;

`ifdef MPT_FETCH_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_accept_cnt_o <= '0;
            perf_fault_cnt_o  <= '0;
        end else begin
            if (grant_any && perf_accept_cnt_o != '1)
                perf_accept_cnt_o <= perf_accept_cnt_o + 32'd1;
            if (grant_any && fault != NO_ERROR && perf_fault_cnt_o != '1)
                perf_fault_cnt_o <= perf_fault_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mpt_multi_fetch_stage.sv
// Randomized bench for mpt_multi_fetch_stage: two instances (mode masks 1110 and 0110)
// share stimulus and are compared against a queue-based reference model.
module tb_mpt_multi_fetch_stage;
    import mpt_fetch_pkg::*;

    localparam int unsigned NCH   = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CHW   = 2;
    localparam int unsigned CNTW  = 2;
    localparam logic [3:0]  MASK_A = 4'b1110;
    localparam logic [3:0]  MASK_B = 4'b0110;

    typedef struct {
        logic [31:0] data;
        int          ch;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic stall = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    mpt_multi_fetch_stage_if #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .CH_W(CHW)) bus_a ();
    mpt_multi_fetch_stage_if #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .CH_W(CHW)) bus_b ();

    assign bus_b.slave_valid  = bus_a.slave_valid;
    assign bus_b.slave_data   = bus_a.slave_data;
    assign bus_b.master_ready = bus_a.master_ready;

    logic               exc_v_a, exc_v_b;
    page_format_fault_e exc_c_a, exc_c_b;
    logic [CHW-1:0]     exc_ch_a, exc_ch_b;
    logic [CNTW-1:0]    cnt_a, cnt_b;
`ifdef MPT_FETCH_PERF_CNT_EN
    logic [31:0] pacc_a, pflt_a, pacc_b, pflt_b;
`endif

    mpt_multi_fetch_stage #(
        .NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SUPPORTED_MODES(MASK_A)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .stage(bus_a.slave),
        .stage_ctrl_flush_i(flush), .stage_ctrl_stall_i(stall),
        .exception_valid_o(exc_v_a), .exception_cause_o(exc_c_a),
        .exception_channel_o(exc_ch_a), .fifo_count_o(cnt_a)
`ifdef MPT_FETCH_PERF_CNT_EN
        , .perf_accept_cnt_o(pacc_a), .perf_fault_cnt_o(pflt_a)
`endif
    );

    mpt_multi_fetch_stage #(
        .NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SUPPORTED_MODES(MASK_B)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .stage(bus_b.slave),
        .stage_ctrl_flush_i(flush), .stage_ctrl_stall_i(stall),
        .exception_valid_o(exc_v_b), .exception_cause_o(exc_c_b),
        .exception_channel_o(exc_ch_b), .fifo_count_o(cnt_b)
`ifdef MPT_FETCH_PERF_CNT_EN
        , .perf_accept_cnt_o(pacc_b), .perf_fault_cnt_o(pflt_b)
`endif
    );

    // reference model state, one set per instance
    ent_t            mq [2][$];
    int              m_rr [2];
    logic            m_ev [2];
    int              m_ecause [2];
    int              m_ech [2];
    longint unsigned m_pacc [2];
    longint unsigned m_pflt [2];

    logic        pend_v [NCH];
    logic [31:0] pend_d [NCH];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // fault code: 0 = none, 1 = not-valid-address
    function automatic int ref_fault(input logic [31:0] w, input logic [3:0] mask);
        int mode;
        mode = int'(w[26:23]);
        if (!w[31]) return 0;
        if (mode > 3) return 1;
        if (!mask[mode]) return 1;
        if (mode == 0) return 1;
        if (mode == 1) return (w[22:18] != 5'd0) ? 1 : 0;
        if (mode == 2) return (w[22:21] != 2'd0) ? 1 : 0;
        return 0;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input int f);
        logic [31:0] s;
        s        = w;
        s[29]    = w[31] && (f == 0);
        s[28:27] = 2'(f);
        if (!w[31]) s[30] = 1'b0;
        return s;
    endfunction

    function automatic logic [31:0] rand_txn();
        logic [31:0] w;
        w     = $urandom();
        w[31] = ($urandom_range(99) < 80);
        if ($urandom_range(4) == 0) w[26:23] = 4'($urandom_range(15, 4));
        else                        w[26:23] = 4'($urandom_range(3));
        if ($urandom_range(1) == 1) w[22:18] = 5'd0;
        return w;
    endfunction

    task automatic sample(input int inst, output logic [NCH-1:0] rdy, output logic mv,
                          output logic [31:0] md, output logic [CHW-1:0] mc, output logic ev,
                          output logic [1:0] ec, output logic [CHW-1:0] ech,
                          output logic [CNTW-1:0] cnt);
        if (inst == 0) begin
            rdy = bus_a.slave_ready; mv = bus_a.master_valid; md = bus_a.master_data;
            mc = bus_a.master_channel; ev = exc_v_a; ec = exc_c_a; ech = exc_ch_a; cnt = cnt_a;
        end else begin
            rdy = bus_b.slave_ready; mv = bus_b.master_valid; md = bus_b.master_data;
            mc = bus_b.master_channel; ev = exc_v_b; ec = exc_c_b; ech = exc_ch_b; cnt = cnt_b;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            m_rr[i] = 0; m_ev[i] = 1'b0; m_ecause[i] = 0; m_ech[i] = 0;
            m_pacc[i] = 0; m_pflt[i] = 0;
        end
    endtask

    task automatic check_reset_outputs(input string why);
        logic [NCH-1:0] rdy; logic mv; logic [31:0] md; logic [CHW-1:0] mc;
        logic ev; logic [1:0] ec; logic [CHW-1:0] ech; logic [CNTW-1:0] cnt;
        for (int i = 0; i < 2; i++) begin
            sample(i, rdy, mv, md, mc, ev, ec, ech, cnt);
            check_eq({why, ".ready"},   64'(rdy), 64'd0);
            check_eq({why, ".mvalid"},  64'(mv),  64'd0);
            check_eq({why, ".mdata"},   64'(md),  64'd0);
            check_eq({why, ".mchan"},   64'(mc),  64'd0);
            check_eq({why, ".exc_v"},   64'(ev),  64'd0);
            check_eq({why, ".exc_c"},   64'(ec),  64'd0);
            check_eq({why, ".exc_ch"},  64'(ech), 64'd0);
            check_eq({why, ".count"},   64'(cnt), 64'd0);
        end
`ifdef MPT_FETCH_PERF_CNT_EN
        check_eq({why, ".perf_acc"}, 64'(pacc_a), 64'd0);
        check_eq({why, ".perf_flt"}, 64'(pflt_b), 64'd0);
`endif
    endtask

    task automatic model_cycle(input int inst, input logic [3:0] mask, output int grant);
        logic [NCH-1:0] rdy, exp_rdy; logic mv; logic [31:0] md; logic [CHW-1:0] mc;
        logic ev; logic [1:0] ec; logic [CHW-1:0] ech; logic [CNTW-1:0] cnt;
        bit pop, acc; int g, f, c; string p; ent_t e;
        sample(inst, rdy, mv, md, mc, ev, ec, ech, cnt);
        p   = (inst == 0) ? "a" : "b";
        pop = (mq[inst].size() > 0) && bus_a.master_ready && !flush;
        acc = !stall && !flush && ((mq[inst].size() < DEPTH) || pop);
        g   = -1;
        if (acc) begin
            for (int n = 0; n < NCH; n++) begin
                c = (m_rr[inst] + n) % NCH;
                if (g < 0 && pend_v[c]) g = c;
            end
        end
        exp_rdy = (g >= 0) ? (NCH'(1) << g) : '0;
        check_eq({p, ".ready"},  64'(rdy), 64'(exp_rdy));
        check_eq({p, ".mvalid"}, 64'(mv),  64'(mq[inst].size() > 0));
        check_eq({p, ".count"},  64'(cnt), 64'(mq[inst].size()));
        if (mq[inst].size() > 0) begin
            check_eq({p, ".mdata"}, 64'(md), 64'(mq[inst][0].data));
            check_eq({p, ".mchan"}, 64'(mc), 64'(mq[inst][0].ch));
        end
        check_eq({p, ".exc_v"},  64'(ev),  64'(m_ev[inst]));
        check_eq({p, ".exc_c"},  64'(ec),  64'(m_ecause[inst]));
        check_eq({p, ".exc_ch"}, 64'(ech), 64'(m_ech[inst]));
`ifdef MPT_FETCH_PERF_CNT_EN
        check_eq({p, ".perf_acc"}, (inst == 0) ? 64'(pacc_a) : 64'(pacc_b), 64'(m_pacc[inst]));
        check_eq({p, ".perf_flt"}, (inst == 0) ? 64'(pflt_a) : 64'(pflt_b), 64'(m_pflt[inst]));
`endif
        f = (g >= 0) ? ref_fault(pend_d[g], mask) : 0;
        if (flush) mq[inst].delete();
        else begin
            if (pop) void'(mq[inst].pop_front());
            if (g >= 0) begin
                e.data = ref_store(pend_d[g], f);
                e.ch   = g;
                mq[inst].push_back(e);
            end
        end
        m_ev[inst] = (g >= 0) && (f != 0);
        if (m_ev[inst]) begin
            m_ecause[inst] = f;
            m_ech[inst]    = g;
        end
        if (g >= 0) begin
            m_rr[inst] = (g + 1) % NCH;
            if (m_pacc[inst] < 64'hFFFF_FFFF) m_pacc[inst]++;
            if (f != 0 && m_pflt[inst] < 64'hFFFF_FFFF) m_pflt[inst]++;
        end
        grant = g;
    endtask

    task automatic cycle(input int p_valid, input int p_ready, input int p_flush, input int p_stall);
        logic [NCH-1:0]    v;
        logic [NCH*DW-1:0] d;
        int g0, g1;
        @(negedge clk);
        for (int k = 0; k < NCH; k++) begin
            if (!pend_v[k] && $urandom_range(99) < p_valid) begin
                pend_v[k] = 1'b1;
                pend_d[k] = rand_txn();
            end
            v[k]          = pend_v[k];
            d[k*DW +: DW] = pend_d[k];
        end
        bus_a.slave_valid  = v;
        bus_a.slave_data   = d;
        bus_a.master_ready = ($urandom_range(99) < p_ready);
        flush              = ($urandom_range(99) < p_flush);
        stall              = ($urandom_range(99) < p_stall);
        #1;
        model_cycle(0, MASK_A, g0);
        model_cycle(1, MASK_B, g1);
        if (g0 >= 0) pend_v[g0] = 1'b0;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus_a.slave_valid  = '0;
        bus_a.slave_data   = '0;
        bus_a.master_ready = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            pend_v[k] = 1'b0;
            pend_d[k] = '0;
        end
        model_reset();
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        repeat (10) cycle(100, 100, 0, 0);       // round-robin, full throughput
        repeat (4)  cycle(100, 0, 0, 0);         // fill to full under backpressure
        repeat (4)  cycle(100, 100, 0, 0);       // pop + accept per cycle while full
        repeat (3)  cycle(100, 0, 0, 0);
        cycle(100, 0, 100, 0);                   // flush with full FIFO
        cycle(100, 100, 0, 0);
        repeat (2)  cycle(100, 0, 0, 0);
        repeat (3)  cycle(100, 100, 0, 100);     // stall, pops continue
        repeat (1500) cycle(50, 60, 4, 15);
        repeat (3)  cycle(100, 0, 0, 0);
        mid_reset();
        repeat (6)  cycle(100, 100, 0, 0);
        repeat (1000) cycle(70, 50, 3, 10);
        mid_reset();
        repeat (200) cycle(60, 70, 2, 10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
